// File: rtl/red_pkg.sv
// Shared encodings for the serial vector reducer: reduction ops and FSM states.
package red_pkg;

  typedef enum logic [1:0] {
    RED_AND  = 2'b00,
    RED_OR   = 2'b01,
    RED_XOR  = 2'b10,
    RED_XNOR = 2'b11
  } red_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } red_state_e;

  // Identity element of the reduction: 1 for AND, 0 for OR/XOR/XNOR.
  function automatic logic acc_seed(input red_op_e o);
    return (o == RED_AND);
  endfunction

endpackage

// File: rtl/reduce_bit_step.sv
// One reduction step: folds a single vector bit into the running accumulator.
module reduce_bit_step
  import red_pkg::*;
(
  input  logic    acc,
  input  logic    b,
  input  red_op_e op,
  output logic    acc_next
);

  // XNOR accumulates as XOR; the inversion happens once on the final result.
  always_comb begin
    acc_next = acc ^ b;
    unique case (op)
      RED_AND: acc_next = acc & b;
      RED_OR:  acc_next = acc | b;
      default: acc_next = acc ^ b;
    endcase
  end

endmodule

// File: rtl/vector_reduce_serial.sv
// Serial bit-at-a-time reduction (AND/OR/XOR/XNOR) of an N-bit vector to one bit,
// with valid/ready handshakes on input and output.
module vector_reduce_serial
  import red_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         y,
  output logic         busy
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  red_state_e     state, state_n;
  logic [N-1:0]   sr;
  logic [CNT_W-1:0] cnt;
  red_op_e        op_r;
  logic           acc, acc_step;
  logic           accept, last;
  logic           in_ready_d, out_valid_d, busy_d, y_d;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CNT_LAST);

  reduce_bit_step u_step (
    .acc      (acc),
    .b        (sr[0]),
    .op       (op_r),
    .acc_next (acc_step)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (accept)                 state_n = ST_SHIFT;
      ST_SHIFT: if (last)                   state_n = ST_DONE;
      ST_DONE:  if (out_valid && out_ready) state_n = ST_IDLE;
      default:                              state_n = ST_IDLE;
    endcase
  end

  // Output next values, decoded from the upcoming state so the ports are registered
  always_comb begin
    in_ready_d  = (state_n == ST_IDLE);
    busy_d      = (state_n != ST_IDLE);
    out_valid_d = (state_n == ST_DONE);
    y_d         = y;
    if (state == ST_SHIFT && last) y_d = acc_step ^ (op_r == RED_XNOR);
  end

  // Datapath: capture on accept, then one bit per cycle LSB first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      op_r <= RED_AND;
      acc  <= 1'b0;
    end else if (state == ST_IDLE && accept) begin
      sr   <= a;
      cnt  <= '0;
      op_r <= red_op_e'(op);
      acc  <= acc_seed(red_op_e'(op));
    end else if (state == ST_SHIFT) begin
      sr  <= sr >> 1;
      acc <= acc_step;
      if (!last) cnt <= cnt + CNT_W'(1);
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      y         <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      y         <= y_d;
    end
  end

endmodule
